// File: rtl/agu_exe_unit.sv
// Load/store AGU: adds base + imm, runs one memory access, and formats the load result or reports the store.
// Latency is issue+2 plus memory wait cycles; agu_busy holds off issue until the op leaves RESP.
// Backpressure: mem_req stays up until mem_ack or TIMEOUT. Macro AGU_MISALIGN_TRAP_EN traps misaligned ops instead of aligning them.
module agu_exe_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic        if_iss,
  input  logic [5:0]  iss_rob_num,
  input  logic [5:0]  iss_rd,
  input  logic        iss_is_store,
  input  logic [1:0]  iss_size,
  input  logic        iss_unsigned,
  input  logic [4:0]  iss_st_num,
  input  logic [31:0] iss_base,
  input  logic [11:0] iss_imm,
  input  logic [31:0] iss_wdata,
  input  logic        rob_flush,
  output logic        agu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        hit_wb_agu,
  output logic [5:0]  rd_agu_wb,
  output logic [31:0] result_agu_wb,
  output logic [4:0]  store_exe_num,
  output logic        exc_valid,
  output logic [5:0]  exc_rob_num,
  output logic [1:0]  exc_code
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_rob_num, r_rd;
  logic        r_is_store, r_unsigned, r_kill, r_exc;
  logic [1:0]  r_size, r_exc_code;
  logic [4:0]  r_st_num;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [CW-1:0] r_tmo_cnt;

  logic        w_issue, w_trap, w_tmo, w_live;
  logic [1:0]  w_size;
  logic [31:0] w_addr_raw, w_addr_al, w_wdata, w_result;
  logic [3:0]  w_be;
  logic [15:0] w_lane;

  assign w_issue    = if_iss & ~rob_flush & (r_state == S_IDLE);
  assign w_size     = (iss_size == 2'd3) ? 2'd2 : iss_size;
  assign w_addr_raw = iss_base + {{20{iss_imm[11]}}, iss_imm};
  assign w_tmo      = (r_state == S_ACCESS) & ~mem_ack & (r_tmo_cnt == CW'(TIMEOUT - 1));
  assign w_live     = ~r_kill & ~rob_flush;

`ifdef AGU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = ((w_size == 2'd1) & w_addr_raw[0]) | ((w_size == 2'd2) & (|w_addr_raw[1:0]));
  assign w_trap  = w_misal;
`else
  assign w_trap  = 1'b0;
`endif

  always_comb begin
    w_addr_al = w_addr_raw;
    if (w_size == 2'd1) w_addr_al[0] = 1'b0;
    if (w_size == 2'd2) w_addr_al[1:0] = 2'b00;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_issue) w_state_nxt = w_trap ? S_RESP : S_ACCESS;
      S_ACCESS: if (mem_ack || w_tmo) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rob_num  <= '0;
      r_rd       <= '0;
      r_is_store <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_st_num   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_kill     <= 1'b0;
      r_exc      <= 1'b0;
      r_exc_code <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_rob_num  <= iss_rob_num;
        r_rd       <= iss_rd;
        r_is_store <= iss_is_store;
        r_unsigned <= iss_unsigned;
        r_size     <= w_size;
        r_st_num   <= iss_st_num;
        r_addr     <= w_addr_al;
        r_wdata    <= iss_wdata;
        r_kill     <= 1'b0;
        r_tmo_cnt  <= '0;
        r_exc      <= w_trap;
        r_exc_code <= w_trap ? 2'd1 : 2'd0;
      end else if (r_state == S_ACCESS) begin
        // A flush cannot abort the bus cycle; it only silences the RESP outputs.
        if (rob_flush) r_kill <= 1'b1;
        if (mem_ack) begin
          r_rdata <= mem_rdata;
        end else if (w_tmo) begin
          r_exc      <= 1'b1;
          r_exc_code <= 2'd2;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_size)
      2'd0: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane = 16'(r_rdata >> {r_addr[1:0], 3'b000});

  always_comb begin
    w_result = r_rdata;
    case (r_size)
      2'd0: w_result = r_unsigned ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      2'd1: w_result = r_unsigned ? {16'h0, w_lane} : {{16{w_lane[15]}}, w_lane};
      default: ;
    endcase
  end

  always_comb begin
    agu_busy      = (r_state != S_IDLE);
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_be        = '0;
    mem_wdata     = '0;
    hit_wb_agu    = 1'b0;
    rd_agu_wb     = '0;
    result_agu_wb = '0;
    store_exe_num = 5'h1F;
    exc_valid     = 1'b0;
    exc_rob_num   = '0;
    exc_code      = '0;
    case (r_state)
      S_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        mem_addr  = r_addr;
        mem_be    = w_be;
        mem_wdata = w_wdata;
      end
      S_RESP: begin
        if (w_live) begin
          if (r_exc) begin
            exc_valid   = 1'b1;
            exc_rob_num = r_rob_num;
            exc_code    = r_exc_code;
          end else if (r_is_store) begin
            store_exe_num = r_st_num;
          end else begin
            hit_wb_agu    = 1'b1;
            rd_agu_wb     = r_rd;
            result_agu_wb = w_result;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_agu_exe_unit.sv
// Randomized bench for agu_exe_unit: a transaction-level model predicts every cycle's outputs.
module tb_agu_exe_unit;
  localparam int TMO = 10;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        if_iss, iss_is_store, iss_unsigned, rob_flush, mem_ack;
  logic [5:0]  iss_rob_num, iss_rd;
  logic [1:0]  iss_size;
  logic [4:0]  iss_st_num;
  logic [31:0] iss_base, iss_wdata, mem_rdata;
  logic [11:0] iss_imm;
  logic        agu_busy, mem_req, mem_we, hit_wb_agu, exc_valid;
  logic [31:0] mem_addr, mem_wdata, result_agu_wb;
  logic [3:0]  mem_be;
  logic [5:0]  rd_agu_wb, exc_rob_num;
  logic [4:0]  store_exe_num;
  logic [1:0]  exc_code;

  agu_exe_unit #(.TIMEOUT(TMO)) dut (
    .clk1(clk1), .reset(reset), .if_iss(if_iss), .iss_rob_num(iss_rob_num), .iss_rd(iss_rd),
    .iss_is_store(iss_is_store), .iss_size(iss_size), .iss_unsigned(iss_unsigned),
    .iss_st_num(iss_st_num), .iss_base(iss_base), .iss_imm(iss_imm), .iss_wdata(iss_wdata),
    .rob_flush(rob_flush), .agu_busy(agu_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_wb_agu(hit_wb_agu), .rd_agu_wb(rd_agu_wb),
    .result_agu_wb(result_agu_wb), .store_exe_num(store_exe_num), .exc_valid(exc_valid),
    .exc_rob_num(exc_rob_num), .exc_code(exc_code)
  );

  always #5 clk1 = ~clk1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        exp_busy, exp_req, exp_we, exp_hit, exp_exc;
  logic [31:0] exp_addr, exp_wd, exp_res;
  logic [3:0]  exp_be;
  logic [5:0]  exp_rd, exp_rob;
  logic [4:0]  exp_stn;
  logic [1:0]  exp_code;

  logic [31:0] obs_addr = '0, obs_wd = '0, obs_res = '0;
  logic [3:0]  obs_be = '0;
  logic [4:0]  obs_stn = '0;
  logic [1:0]  obs_code = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk1) begin
    if (chk_en) begin
      chk("agu_busy", 32'(agu_busy), 32'(exp_busy));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      end
      chk("hit_wb_agu", 32'(hit_wb_agu), 32'(exp_hit));
      if (exp_hit || !exp_busy) begin
        chk("rd_agu_wb", 32'(rd_agu_wb), 32'(exp_rd));
        chk("result_agu_wb", result_agu_wb, exp_res);
      end
      chk("store_exe_num", 32'(store_exe_num), 32'(exp_stn));
      chk("exc_valid", 32'(exc_valid), 32'(exp_exc));
      if (exp_exc) begin
        chk("exc_rob_num", 32'(exc_rob_num), 32'(exp_rob));
        chk("exc_code", 32'(exc_code), 32'(exp_code));
      end
      if (mem_req) begin
        obs_addr <= mem_addr;
        obs_be   <= mem_be;
        obs_wd   <= mem_wdata;
      end
      if (hit_wb_agu) obs_res <= result_agu_wb;
      if (store_exe_num != 5'h1F) obs_stn <= store_exe_num;
      if (exc_valid) obs_code <= exc_code;
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wd = '0;
    exp_hit = 1'b0; exp_rd = '0; exp_res = '0; exp_stn = 5'h1F;
    exp_exc = 1'b0; exp_rob = '0; exp_code = '0;
  endtask

  task automatic rand_iss();
    if_iss       = 1'($urandom);
    iss_rob_num  = 6'($urandom);
    iss_rd       = 6'($urandom);
    iss_is_store = 1'($urandom);
    iss_size     = 2'($urandom);
    iss_unsigned = 1'($urandom);
    iss_st_num   = 5'($urandom);
    iss_base     = $urandom;
    iss_imm      = 12'($urandom);
    iss_wdata    = $urandom;
  endtask

  function automatic logic [31:0] load_fmt(input logic [31:0] rd, input logic [1:0] lane,
                                           input int sz, input bit uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*lane +: 8];
    h = rd[8*lane +: 16];
    if (sz == 0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  task automatic idle_cycle(input bit flush_issue);
    step();
    rand_iss();
    if_iss = flush_issue;
    rob_flush = flush_issue;
    mem_ack = 1'($urandom);
    set_idle_exp();
    @(negedge clk1);
    #1;
  endtask

  task automatic do_op(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] base,
                       input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] stn,
                       input logic [31:0] rdata, input int ack_dly, input int flush_k,
                       input bit flush_resp);
    logic [5:0]  rob, rd;
    logic [31:0] a, al, ewd;
    logic [3:0]  be;
    int          esz, k;
    bit          misal, acked, killed, sup;
    rob = 6'($urandom);
    rd  = 6'($urandom);
    esz = (sz == 2'd3) ? 2 : int'(sz);
    a   = base + {{20{imm[11]}}, imm};
    misal = (esz == 1 && a[0]) || (esz == 2 && a[1:0] != 2'b00);
    al  = a;
    if (esz == 1) al = a & 32'hFFFF_FFFE;
    if (esz == 2) al = a & 32'hFFFF_FFFC;
    if (esz == 0)      begin be = 4'b0001 << al[1:0]; ewd = {4{wd[7:0]}}; end
    else if (esz == 1) begin be = 4'b0011 << al[1:0]; ewd = {2{wd[15:0]}}; end
    else               begin be = 4'hF; ewd = wd; end

    step();
    if_iss = 1'b1; iss_rob_num = rob; iss_rd = rd; iss_is_store = st; iss_size = sz;
    iss_unsigned = uns; iss_st_num = stn; iss_base = base; iss_imm = imm; iss_wdata = wd;
    rob_flush = 1'b0; mem_ack = 1'($urandom);
    set_idle_exp();

`ifdef AGU_MISALIGN_TRAP_EN
    if (misal) begin
      step();
      rand_iss();
      rob_flush = flush_resp; mem_ack = 1'($urandom);
      set_idle_exp();
      exp_busy = 1'b1; exp_exc = !flush_resp; exp_rob = rob; exp_code = 2'd1;
      return;
    end
`endif

    k = 0; acked = 1'b0; killed = 1'b0;
    forever begin
      step();
      rand_iss();
      rob_flush = (k == flush_k);
      mem_ack   = (k == ack_dly);
      mem_rdata = (k == ack_dly) ? rdata : $urandom;
      set_idle_exp();
      exp_busy = 1'b1; exp_req = 1'b1; exp_addr = al; exp_be = be; exp_we = st; exp_wd = ewd;
      if (k == flush_k) killed = 1'b1;
      if (k == ack_dly) begin acked = 1'b1; break; end
      if (k == TMO - 1) break;
      k++;
    end

    step();
    rand_iss();
    rob_flush = flush_resp; mem_ack = 1'($urandom);
    sup = killed || flush_resp;
    set_idle_exp();
    exp_busy = 1'b1;
    if (!acked) begin
      exp_exc = !sup; exp_rob = rob; exp_code = 2'd2;
    end else if (st) begin
      exp_stn = sup ? 5'h1F : stn;
    end else if (!sup) begin
      exp_hit = 1'b1; exp_rd = rd; exp_res = load_fmt(rdata, al[1:0], esz, uns);
    end
  endtask

  initial begin
    reset = 1'b0; if_iss = 1'b0; rob_flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    iss_rob_num = '0; iss_rd = '0; iss_is_store = 1'b0; iss_size = '0; iss_unsigned = 1'b0;
    iss_st_num = '0; iss_base = '0; iss_imm = '0; iss_wdata = '0;
    set_idle_exp();
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_busy", 32'(agu_busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_stn", 32'(store_exe_num), 32'h1F);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_exc_code", 32'(exc_code), 32'd0);
    chk("rst_hit", 32'(hit_wb_agu), 32'd0);
    step();
    reset = 1'b1;
    chk_en = 1'b1;
    idle_cycle(0);

    do_op(0, 2'd2, 0, 32'h1000, 12'h004, 32'h0, 5'd0, 32'hDEAD_BEEF, 0, -1, 0);
    idle_cycle(0);
    chk("lw_addr", obs_addr, 32'h0000_1004);
    chk("lw_be", 32'(obs_be), 32'hF);
    chk("lw_result", obs_res, 32'hDEAD_BEEF);

    do_op(0, 2'd0, 0, 32'h2000, 12'hFFF, 32'h0, 5'd0, 32'h80FF_0000, 0, -1, 0);
    idle_cycle(0);
    chk("lb_addr", obs_addr, 32'h0000_1FFF);
    chk("lb_be", 32'(obs_be), 32'h8);
    chk("lb_result", obs_res, 32'hFFFF_FF80);
    do_op(0, 2'd0, 1, 32'h2000, 12'hFFF, 32'h0, 5'd0, 32'h80FF_0000, 1, -1, 0);
    idle_cycle(0);
    chk("lbu_result", obs_res, 32'h0000_0080);

    do_op(1, 2'd1, 0, 32'h3002, 12'h000, 32'h0000_1234, 5'd7, 32'h0, 3, -1, 0);
    idle_cycle(0);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wd, 32'h1234_1234);
    chk("sh_stn", 32'(obs_stn), 32'd7);

    do_op(0, 2'd2, 0, 32'h5000, 12'h010, 32'h0, 5'd0, 32'h1111_2222, 3, 1, 0);
    idle_cycle(0);
    do_op(1, 2'd2, 0, 32'h6000, 12'h000, 32'hCAFE_F00D, 5'd3, 32'h0, TMO + 5, -1, 0);
    idle_cycle(0);
    chk("timeout_code", 32'(obs_code), 32'd2);

    do_op(0, 2'd2, 0, 32'h1002, 12'h000, 32'h0, 5'd0, 32'h5555_AAAA, 0, -1, 0);
    idle_cycle(0);
`ifdef AGU_MISALIGN_TRAP_EN
    chk("misalign_code", 32'(obs_code), 32'd1);
`else
    chk("misalign_forced_addr", obs_addr, 32'h0000_1000);
`endif

    do_op(0, 2'd3, 1, 32'h7000, 12'h008, 32'h0, 5'd0, 32'h0BAD_F00D, 2, -1, 1);
    idle_cycle(1);
    idle_cycle(0);

    step();
    if_iss = 1'b1; iss_is_store = 1'b0; iss_size = 2'd2; iss_base = 32'h4000; iss_imm = '0;
    rob_flush = 1'b0; mem_ack = 1'b0;
    set_idle_exp();
    step();
    if_iss = 1'b0; mem_ack = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b1; exp_addr = 32'h4000; exp_be = 4'hF; exp_we = 1'b0;
    @(negedge clk1);
    #1;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstmid_req", 32'(mem_req), 32'd0);
    chk("rstmid_busy", 32'(agu_busy), 32'd0);
    chk("rstmid_addr", mem_addr, 32'd0);
    step();
    reset = 1'b1;
    set_idle_exp();
    chk_en = 1'b1;
    idle_cycle(0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] b;
      int fk;
      b  = $urandom;
      fk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      do_op(1'($urandom), 2'($urandom), 1'($urandom), b, 12'($urandom), $urandom, 5'($urandom),
            $urandom, $urandom_range(0, TMO), fk, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1);
    end
    idle_cycle(0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/agu_exe_unit.md
AGU_EXE_UNIT -- requirements
Module: agu_exe_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning mem_ack wait-cycle limit before bus error is raised.
REQ-002 SHALL have ports:
- clk1  in  1  sole clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_iss  in  1  issue valid from AGU reservation station.
- iss_rob_num  in  6  ROB tag of issued op.
- iss_rd  in  6  destination physical reg.
- iss_is_store  in  1  1 = store, 0 = load.
- iss_size  in  2  0 = byte, 1 = half, 2 = word.
- iss_unsigned  in  1  load zero-extend.
- iss_st_num  in  5  store sequence number.
- iss_base  in  32  rs1 value.
- iss_imm  in  12  signed offset.
- iss_wdata  in  32  rs2 store data.
- rob_flush  in  1  kill in-flight op.
- agu_busy  out  1  unit cannot accept issue.
- mem_req, mem_we  out  1 each  memory request / write.
- mem_addr  out  32  byte address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  request accepted, rdata valid.
- mem_rdata  in  32  load word.
- hit_wb_agu  out  1  load writeback valid.
- rd_agu_wb  out  6  writeback reg.
- result_agu_wb  out  32  formatted load data.
- store_exe_num  out  5  completed store number; 5'h1F when none.
- exc_valid  out  1  exception pulse.
- exc_rob_num  out  6  excepting ROB tag.
- exc_code  out  2  1 = misaligned, 2 = bus timeout.

Function
REQ-003 SHALL implement FSM IDLE, ACCESS, RESP; agu_busy = (state != IDLE).
REQ-004 In IDLE with if_iss = 1: latch all iss_* fields; compute addr = iss_base + sign-extended iss_imm (mod 2^32); go to ACCESS next cycle. if_iss while busy SHALL be ignored.
REQ-005 In ACCESS: mem_req = 1 and mem_addr/mem_we/mem_be/mem_wdata held stable until the mem_ack cycle.
REQ-006 mem_be: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111. mem_wdata = iss_wdata replicated to the selected lane.
REQ-007 On mem_ack in ACCESS: go to RESP; capture mem_rdata.
REQ-008 In RESP (exactly 1 cycle, then IDLE), load: hit_wb_agu = 1, rd_agu_wb = latched rd, result_agu_wb = lane selected by addr[1:0], sign- or zero-extended per iss_unsigned.
REQ-009 In RESP, store: store_exe_num = latched iss_st_num for that cycle; hit_wb_agu = 0.
REQ-010 Issue-to-writeback latency SHALL be 2 cycles + memory wait cycles (ack in first ACCESS cycle: writeback at issue+2).
REQ-011 Counter in ACCESS: after TIMEOUT cycles without ack, go to RESP with exc_valid = 1, exc_code = 2, no writeback and no store_exe_num.
REQ-012 rob_flush in ACCESS SHALL NOT drop mem_req (bus must complete); it sets kill flag; RESP then suppresses hit_wb_agu, store_exe_num and exc_valid. rob_flush in IDLE blocks a same-cycle issue. rob_flush in RESP suppresses that cycle's outputs.
REQ-013 Idle outputs: hit_wb_agu = 0, rd_agu_wb = 0, result_agu_wb = 0, store_exe_num = 5'h1F, exc_valid = 0, mem_req = 0.
REQ-014 iss_size = 3 SHALL be treated as word.

Reset
REQ-015 reset low SHALL asynchronously force IDLE, clear kill flag and timeout counter, and drive all outputs to REQ-013 values, with mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0 and exc_code = 0; a reset during ACCESS abandons the request.

Configuration
REQ-016 With AGU_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) SHALL skip ACCESS, enter RESP next cycle with exc_valid = 1, exc_code = 1, exc_rob_num = tag, and make no memory request.
REQ-017 Without AGU_MISALIGN_TRAP_EN, misaligned addresses SHALL be forced aligned (addr[0] cleared for half, addr[1:0] cleared for word) and the access proceeds normally; exc_code 1 is never produced.

Verification
REQ-018 Load word: base 0x1000, imm 0x004, ack in the first ACCESS cycle, rdata 0xDEADBEEF -> mem_addr 0x1004, be 4'hF; at issue+2, hit_wb_agu = 1, result_agu_wb = 0xDEADBEEF.
REQ-019 Signed byte load: base 0x2000, imm -1, rdata 0x80FF_0000 -> addr 0x1FFF, be 4'b1000, result_agu_wb 0xFFFFFF80; with unsigned -> 0x00000080.
REQ-020 Store half: addr 0x3002, wdata 0x1234, st_num 7, ack delayed 3 cycles -> be 4'b1100, wdata 0x12341234; store_exe_num = 7 for one cycle, then 5'h1F.
REQ-021 Flush mid-ACCESS: rob_flush pulsed before ack -> mem_req held until ack; no hit_wb_agu, then IDLE.
REQ-022 No ack for TIMEOUT cycles -> exc_valid = 1, exc_code = 2; word at 0x1002 with AGU_MISALIGN_TRAP_EN -> exc_code = 1, mem_req never asserted.
